// File: rtl/dctq_accum8.sv
// dctq_accum8: signed group accumulator with rounding quantizer.
// Sums GROUP products into one coefficient, then rounds, shifts and saturates.
module dctq_accum8 #(
    parameter int IN_W  = 19,
    parameter int GROUP = 8,
    parameter int SHIFT = 8,
    parameter int OUT_W = 11,
    localparam int ACC_W = IN_W + $clog2(GROUP)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_sum,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_sat,
    output logic                    grp_err
);

    localparam int CNT_W = $clog2(GROUP);
    localparam int AW1   = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUP - 1);
    localparam logic signed [AW1-1:0] HALF  = AW1'(1) << (SHIFT - 1);
    localparam logic signed [AW1-1:0] Q_MAX = AW1'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [AW1-1:0] Q_MIN = ~Q_MAX;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic signed [OUT_W-1:0] coef_q, coef_d;
    logic                    sat_q, sat_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic signed [ACC_W-1:0] samp;
    logic signed [ACC_W-1:0] nxt;
    logic                    start;
    logic                    last;
    logic signed [AW1-1:0]   sum_ext;
    logic signed [AW1-1:0]   rnd;
    logic signed [AW1-1:0]   r;
    logic                    hi;
    logic                    lo;

    // Running sum including the current sample; a new group restarts at it.
    always_comb begin
        samp  = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
        start = (cnt_q == '0) || in_first;
        last  = (cnt_q == CNT_LAST) && !in_first;
        nxt   = start ? samp : acc_q + samp;
    end

    // Round half toward +inf, arithmetic shift, clip to the output range.
    always_comb begin
        sum_ext = {nxt[ACC_W-1], nxt};
        rnd     = sum_ext + HALF;
        r       = rnd >>> SHIFT;
        hi      = r > Q_MAX;
        lo      = r < Q_MIN;
        if (hi) begin
            coef_d = Q_MAX[OUT_W-1:0];
        end else if (lo) begin
            coef_d = Q_MIN[OUT_W-1:0];
        end else begin
            coef_d = r[OUT_W-1:0];
        end
        sat_d = hi || lo;
    end

    // Next-state for counter, accumulator and result registers.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (in_valid) begin
            err_d = in_first && (cnt_q != '0);
            if (last) begin
                sum_d   = nxt;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = nxt;
                cnt_d = in_first ? CNT_W'(1) : cnt_q + CNT_W'(1);
            end
        end
    end

    // Accumulation state, with reset dropping any partial group.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    // Result registers hold until the next group completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            coef_q <= '0;
            sat_q  <= 1'b0;
        end else if (valid_d) begin
            sum_q  <= sum_d;
            coef_q <= coef_d;
            sat_q  <= sat_d;
        end
    end

    // Single-cycle result and abandoned-group pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_q     = coef_q;
    assign out_sat   = sat_q;
    assign grp_err   = err_q;

endmodule

// File: tb/tb_dctq_accum8.sv
// tb_dctq_accum8: vector table, corner sequences and random stimulus
// checked against a group-sum reference model.
module tb_dctq_accum8;

    localparam int IN_W  = 19;
    localparam int GROUP = 8;
    localparam int SHIFT = 8;
    localparam int OUT_W = 11;
    localparam int ACC_W = 22;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_first = 1'b0;
    logic signed [IN_W-1:0]  in_data = '0;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_sum;
    logic signed [OUT_W-1:0] out_q;
    logic                    out_sat;
    logic                    grp_err;

    dctq_accum8 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_first (in_first),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_sum  (out_sum),
        .out_q    (out_q),
        .out_sat  (out_sat),
        .grp_err  (grp_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int     due;
        longint sum;
        int     q;
        bit     sat;
    } exp_t;

    exp_t expq[$];
    int   errq[$];
    int   grp[$];

    function automatic exp_t ref_result(int due, int vals[$]);
        exp_t e;
        longint s = 0;
        longint r;
        foreach (vals[i]) s += vals[i];
        r = (s + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        e.due = due;
        e.sum = s;
        e.sat = 1'b0;
        if (r > (2 ** (OUT_W - 1)) - 1) begin
            e.q = (2 ** (OUT_W - 1)) - 1;
            e.sat = 1'b1;
        end else if (r < -(2 ** (OUT_W - 1))) begin
            e.q = -(2 ** (OUT_W - 1));
            e.sat = 1'b1;
        end else begin
            e.q = int'(r);
        end
        return e;
    endfunction

    // Model: applies an accepted sample at edge number cyc.
    task automatic model_accept(bit f, int d);
        if (f && grp.size() != 0) begin
            errq.push_back(cyc);
            grp.delete();
        end
        grp.push_back(d);
        if (grp.size() == GROUP) begin
            expq.push_back(ref_result(cyc, grp));
            grp.delete();
        end
    endtask

    // One clock: drive, take the edge, update the model just after it.
    task automatic step(bit v, bit f, int d);
        bit r_now;
        in_valid = v;
        in_first = f;
        in_data  = IN_W'(d);
        r_now    = rst;
        @(posedge clk);
        #1;
        if (r_now) grp.delete();
        else if (v) model_accept(f, d);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    // Scoreboard for result and error pulses.
    always @(negedge clk) begin
        bit ev;
        bit ee;
        exp_t e;
        ev = (expq.size() != 0) && (expq[0].due == cyc);
        ee = (errq.size() != 0) && (errq[0] == cyc);
        if (ev || out_valid) begin
            chk("sb_out_valid", longint'(out_valid), longint'(ev));
            if (ev) begin
                e = expq.pop_front();
                if (out_valid) begin
                    chk("sb_out_sum", longint'(out_sum), e.sum);
                    chk("sb_out_q", longint'(out_q), longint'(e.q));
                    chk("sb_out_sat", longint'(out_sat), longint'(e.sat));
                end
            end
        end
        if (ee || grp_err) begin
            chk("sb_grp_err", longint'(grp_err), longint'(ee));
            if (ee) void'(errq.pop_front());
        end
    end

    typedef struct {
        int     d[GROUP];
        longint sum;
        int     q;
        bit     sat;
    } vec_t;

    vec_t vt[7];

    task automatic set_vec(int i, int fill, int lastv, longint s, int q, bit sat);
        for (int k = 0; k < GROUP - 1; k++) vt[i].d[k] = fill;
        vt[i].d[GROUP-1] = lastv;
        vt[i].sum = s;
        vt[i].q   = q;
        vt[i].sat = sat;
    endtask

    initial begin
        set_vec(0, 1000, 1000, 8000, 31, 1'b0);
        set_vec(1, 0, 128, 128, 1, 1'b0);
        set_vec(2, 0, 127, 127, 0, 1'b0);
        set_vec(3, 0, -128, -128, 0, 1'b0);
        set_vec(4, 0, -129, -129, -1, 1'b0);
        set_vec(5, -262144, -262144, -2097152, -1024, 1'b1);
        set_vec(6, 262143, 262143, 2097144, 1023, 1'b1);

        rst = 1'b1;
        step(1, 0, 77);
        step(0, 0, 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_sum", longint'(out_sum), 0);
        chk("rst_out_q", longint'(out_q), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        chk("rst_grp_err", longint'(grp_err), 0);
        rst = 1'b0;
        step(0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < GROUP; k++) step(1, k == 0, vt[i].d[k]);
            chk($sformatf("vec%0d_valid", i), longint'(out_valid), 1);
            chk($sformatf("vec%0d_sum", i), longint'(out_sum), vt[i].sum);
            chk($sformatf("vec%0d_q", i), longint'(out_q), longint'(vt[i].q));
            chk($sformatf("vec%0d_sat", i), longint'(out_sat), longint'(vt[i].sat));
        end
        step(0, 0, 0);
        chk("hold_sum", longint'(out_sum), 2097144);
        chk("hold_valid_drop", longint'(out_valid), 0);

        for (int k = 0; k < GROUP; k++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(0, 1, 0);
            step(1, 0, 1000);
        end
        chk("gap_valid", longint'(out_valid), 1);
        chk("gap_sum", longint'(out_sum), 8000);
        chk("gap_q", longint'(out_q), 31);

        for (int k = 0; k < 3; k++) step(1, k == 0, 50);
        step(1, 1, 1);
        chk("abandon_err", longint'(grp_err), 1);
        for (int k = 1; k < GROUP; k++) step(1, 0, 1);
        chk("abandon_sum", longint'(out_sum), 8);
        chk("abandon_q", longint'(out_q), 0);

        for (int k = 0; k < 5; k++) step(1, 0, 2);
        rst = 1'b1;
        step(1, 0, 2);
        chk("midrst_sum", longint'(out_sum), 0);
        chk("midrst_q", longint'(out_q), 0);
        chk("midrst_err", longint'(grp_err), 0);
        rst = 1'b0;
        for (int k = 0; k < GROUP; k++) step(1, 0, 2);
        chk("midrst_valid", longint'(out_valid), 1);
        chk("midrst_after_sum", longint'(out_sum), 16);
        chk("midrst_after_q", longint'(out_q), 0);

        for (int n = 0; n < 800; n++) begin
            logic signed [IN_W-1:0] r19;
            int sel = $urandom_range(0, 9);
            r19 = IN_W'($urandom);
            if (sel == 0) r19 = {1'b1, {(IN_W-1){1'b0}}};
            if (sel == 1) r19 = {1'b0, {(IN_W-1){1'b1}}};
            if (sel == 2) r19 = IN_W'($urandom_range(0, 300)) - IN_W'(150);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, int'(r19));
        end
        step(0, 0, 0);
        step(0, 0, 0);
        chk("drain_results", longint'(expq.size()), 0);
        chk("drain_errors", longint'(errq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dctq_accum8.md
# dctq_accum8

Signed accumulate-and-quantize stage placed directly downstream of the 11s x 8s pipelined multiplier in the DCTQ datapath. It consumes the multiplier's 19-bit signed products one per valid cycle and sums each group of 8 into a full-precision dot product (one DCT coefficient). It then emits the full sum together with a rounded, right-shifted and saturated 11-bit coefficient for the quantizer/transpose stage.

## Interface
- IN_W, 19, signed product width (matches multiplier result)
- GROUP, 8, products per output; power of two, >= 2
- SHIFT, 8, arithmetic right shift applied to the sum for out_q (>= 1)
- OUT_W, 11, width of the quantized coefficient
- ACC_W (localparam), IN_W + log2(GROUP) = 22, accumulator width; cannot overflow

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data carries a product this cycle
- in_first  in  1  qualified by in_valid: this product is element 0 of a new group
- in_data  in  IN_W  signed two's-complement product
- out_valid  out  1  one-cycle pulse: out_sum/out_q/out_sat hold a new group result
- out_sum  out  ACC_W  signed sum of the GROUP products
- out_q  out  OUT_W  rounded, shifted, saturated coefficient
- out_sat  out  1  out_q was clipped in this result
- grp_err  out  1  one-cycle pulse: a group was abandoned by in_first

## Operation
- State: element counter cnt (0..GROUP-1), accumulator acc (ACC_W, signed), output registers.
- Only cycles with in_valid=1 are counted; in_valid gaps of any length are allowed and freeze all state.
- Sample s = sign-extended in_data. If cnt==0 or in_first=1: next = s, else next = acc + s.
- If the element count reaches GROUP (cnt==GROUP-1 with no in_first, or GROUP==1 path unused): register out_sum=next, out_q, out_sat, pulse out_valid; acc<=0, cnt<=0.
- Otherwise acc<=next, cnt<=cnt+1 (cnt<=1 when in_first).
- in_first with in_valid while cnt!=0: partial group discarded, the sample becomes element 0, grp_err pulses next cycle. in_first with cnt==0: normal, no error. in_first without in_valid: ignored.
- Quantization: r = (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic, i.e. round half toward +inf), computed at ACC_W+1 bits. If r > 2^(OUT_W-1)-1 then out_q = 2^(OUT_W-1)-1 (1023), out_sat=1. If r < -2^(OUT_W-1) then out_q = -2^(OUT_W-1) (-1024), out_sat=1. Otherwise out_q = r, out_sat=0.
- out_sum, out_q, out_sat hold their values until the next group completes; out_valid and grp_err are single-cycle pulses.

## Timing
- Latency: last product of a group accepted at edge t -> out_valid=1 during cycle t+1 (one register stage).
- Throughput: one product per cycle; a group may complete in back-to-back cycles with the next group's first product (no bubble required).
- Reset (rst=1 at an edge): cnt=0, acc=0, out_valid=0, out_sum=0, out_q=0, out_sat=0, grp_err=0. Reset mid-group discards the partial group without grp_err; the first valid sample after reset is element 0.
- rst has priority over in_valid in the same cycle.

## Test plan
- 8 consecutive valid products of +1000 -> one out_valid pulse 1 cycle after the 8th; out_sum=8000, out_q=31, out_sat=0.
- Rounding: groups summing to 128, 127, -128, -129 (e.g. seven 0 + final value) -> out_q = 1, 0, 0, -1 respectively.
- 8 products of -262144 -> out_sum=-2097152, out_q=-1024, out_sat=1; 8 products of +262143 -> out_sum=2097144, out_q=1023, out_sat=1.
- Same 8 products of +1000 with random 0-3 cycle in_valid gaps -> identical result; out_valid exactly 1 cycle after the 8th accepted sample; no pulse otherwise.
- 3 products of 50, then in_first with 8 products of +1 -> grp_err pulse cycle after the in_first sample, then out_sum=8, out_q=0; no result for the abandoned group.
- rst asserted after 5 products, then 8 products of +2 -> outputs 0 during/after reset, no grp_err, then out_sum=16, out_q=0.
